add2_result_uart_tx: RTL
========================

# add2_result_uart_tx

Downstream stage of the 8-bit add/subtract block. It accepts one 9-bit sum and one 9-bit difference per handshake and buffers them in a small FIFO. Each entry goes out as a 4-byte frame on a UART 8N1 transmit line, giving the board a serial readout of adder results.

## Interface
- clock_freq_hz, 50_000_000, system clock frequency in Hz
- baud_rate, 115_200, UART bit rate
- fifo_depth, 4, entries buffered; power of two, ≥ 2
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset; one clock, reset is synchronous and active-low
- in_valid  input  1  result pair presented
- in_ready  output  1  FIFO can accept an entry
- result_add  input  9  sum from upstream adder
- result_sub  input  9  difference from upstream adder (two's complement, 9-bit)
- tx  output  1  UART serial line, idle high
- busy  output  1  frame in progress or FIFO non-empty
- overflow  output  1  sticky: an entry was offered while full

## Operation
- Bit period: BIT_CYC = clock_freq_hz / baud_rate, integer truncation (434 at defaults). Baud counter counts 0..BIT_CYC-1.
- Push:
  - in_valid && in_ready at a rising edge writes {result_add, result_sub} (18 bits) at the write pointer.
  - Pointers are log2(fifo_depth) bits wide and wrap naturally.
  - Occupancy count is 0..fifo_depth.
- in_ready = (count != fifo_depth). A pop in the same cycle does not raise in_ready when full.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- in_valid while full: entry is dropped, FIFO is unchanged, and overflow sets to 1. Overflow stays 1 until reset.
- Frame, 4 bytes, in this order:
  - 0xA5 (sync)
  - result_add[7:0]
  - result_sub[7:0]
  - {6'b0, result_sub[8], result_add[8]}
- Each byte is sent as a start bit (0), then 8 data bits LSB first, then a stop bit (1). Each bit lasts exactly BIT_CYC cycles.
- States:
  - IDLE: tx=1. If FIFO is non-empty, pop the head into an 18-bit frame register, set byte index to 0, go to START.
  - START: tx=0 for BIT_CYC cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte[bit index] for BIT_CYC cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for BIT_CYC cycles. Then:
    - if byte index < 3, increment it and go to START;
    - otherwise go to IDLE.
- Frames run back-to-back. After STOP of byte 3 the block passes through IDLE for exactly one cycle, then START begins if the FIFO is non-empty.
- busy = (state != IDLE) || (count != 0).
- tx is driven from a register, so there are no combinational glitches.

## Timing
- Reset (rst_n low at a rising edge) sets:
  - tx=1, busy=0, overflow=0, count=0;
  - both pointers 0, state IDLE, all counters 0.
- in_ready is forced to 0 while rst_n is low and becomes 1 in the first cycle after release.
- Reset mid-frame aborts the frame. tx is 1 from the next edge, and buffered entries are discarded.
- Latency with the FIFO empty and state IDLE:
  - accepting edge E writes the FIFO;
  - at edge E+1 IDLE pops and enters START;
  - tx is 0 from edge E+2.
- Frame duration: 40 × BIT_CYC cycles of line time, plus 1 IDLE cycle between frames.
- Pop occurs at the IDLE→START edge. count drops, and in_ready rises, one cycle after that edge.
- The upstream stage may present a new pair every cycle. Throughput is limited by the UART rate, and backpressure comes via in_ready.

## Test plan
- Basic frame:
  - stimulus: reset, then push add=0x0FF, sub=0x101 with clock_freq_hz=8, baud_rate=1 (BIT_CYC=8);
  - required: tx low at E+2, then bytes 0xA5, 0xFF, 0x01, 0x02, each 80 cycles, LSB first;
  - required: busy falls one cycle after the last stop bit.
- Sign and carry bits:
  - stimulus: push add=0x100, sub=0x1FF;
  - required: byte1=0x00, byte2=0xFF, byte3=0x03.
- FIFO full and overflow:
  - stimulus: with fifo_depth=4, push 6 entries on consecutive cycles while the first frame is starting;
  - required: one entry is popped, so 5 are accepted;
  - required: the 6th sees in_ready=0 and is dropped, and overflow becomes 1 and stays 1;
  - required: 5 frames go out in order.
- Wrap-around:
  - stimulus: push 10 distinct pairs, spaced so the FIFO never fills;
  - required: all 10 frames are emitted in push order, exercising pointer wrap.
- Reset mid-frame:
  - stimulus: assert rst_n low during the DATA bit 3 of byte 1 with 2 entries queued;
  - required: next edge gives tx=1, busy=0, overflow=0;
  - required: after release, no frame is sent until a new push.
- Back-to-back frames:
  - stimulus: push 2 entries on one cycle each;
  - required: exactly 1 idle cycle of tx=1 beyond the stop bit between frame 1 byte 3 and frame 2 start.

Source files
------------

// File: rtl/add2_result_uart_tx.sv
// add2_result_uart_tx: buffers {sum, difference} pairs from the 8-bit add/sub
// block in a small FIFO and serialises each entry as a 4-byte UART 8N1 frame:
// 0xA5, add[7:0], sub[7:0], {6'b0, sub[8], add[8]}.
module add2_result_uart_tx #(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] result_add,
  input  logic [8:0] result_sub,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BIT_CYC = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [17:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  // Frame register: [17:9] = sum, [8:0] = difference
  logic [17:0]       frame;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [7:0]        cur_byte;

  logic              push;
  logic              pop;
  logic              baud_done;
  logic              tx_nxt;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign push      = in_valid && in_ready;

  // State register; tx is registered here so the line never glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
    end
  end

  // Next-state: one START/8xDATA/STOP sequence per byte, four bytes per frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_START;
      S_START: if (baud_done) state_nxt = S_DATA;
      S_DATA:  if (baud_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (baud_done) state_nxt = (byte_idx == 2'd3) ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: next line level, handshake, busy flag and the FIFO pop strobe
  always_comb begin
    in_ready = rst_n && (count != CNT_FULL);
    busy     = (state != S_IDLE) || (count != '0);
    pop      = (state == S_IDLE) && (count != '0);
    case (state)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = cur_byte[bit_idx];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Byte currently on the wire, selected from the frame register
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = frame[16:9];
      2'd2:    cur_byte = frame[7:0];
      default: cur_byte = {6'b0, frame[8], frame[17]};
    endcase
  end

  // Bit-period timer plus bit and byte position within the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if ((state == S_IDLE) || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_ONE;
      end

      if (state == S_START) begin
        bit_idx <= '0;
      end else if ((state == S_DATA) && baud_done) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (pop) begin
        byte_idx <= '0;
      end else if ((state == S_STOP) && baud_done && (byte_idx != 2'd3)) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // FIFO bookkeeping: pointers wrap naturally, count spans 0..FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // FIFO storage and frame capture; pure data, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {result_add, result_sub};
    if (pop)  frame <= mem[rd_ptr];
  end

endmodule
